fpu_issuer: RTL

FPU_ISSUER -- requirements
Module: fpu_issuer

---
 rtl/fpu_issuer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fpu_issuer.sv
// Request FIFO feeding a single multi-cycle FPU through an IDLE/ISSUE/WAIT/RESP sequencer.
// Define FPU_ISSUER_TIMEOUT_EN to compile in the WAIT-state watchdog (qNaN + rsp_timeout on expiry).
module fpu_issuer #(
    parameter int DEPTH          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_tag,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_r,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_r,
    output logic [4:0]  rsp_tag,
    output logic        rsp_timeout
);

    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = AW + 1;

    if (!(DEPTH == 2 || DEPTH == 4) ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_cfg_err
        $error("fpu_issuer: illegal DEPTH or TIMEOUT_CYCLES");
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic          push;
    logic          pop;

    assign req_ready = (count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: req_a, b: req_b, op: req_op, tag: req_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FPU_ISSUER_TIMEOUT_EN
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fpu_start <= 1'b0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_tag   <= '0;
`ifdef FPU_ISSUER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            fpu_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        fpu_a     <= mem[rd_ptr].a;
                        fpu_b     <= mem[rd_ptr].b;
                        fpu_op    <= mem[rd_ptr].op;
                        rsp_tag   <= mem[rd_ptr].tag;
                        fpu_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef FPU_ISSUER_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (fpu_done) begin
                        rsp_r     <= fpu_r;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef FPU_ISSUER_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
                    end else if (wd_cnt == WD_LIMIT) begin
                        // FPU never answered: hand back a quiet NaN
                        rsp_r       <= QNAN;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
